// File: rtl/gf180mcu_fd_sc_mcu9t5v0_oai211_bist.sv
// oai211 cell BIST engine: walks all 16 input vectors and counts ZN mismatches.
// Optional first-failure log: GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN.
module gf180mcu_fd_sc_mcu9t5v0_oai211_bist #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             ZN_IN,
  output logic             A1,
  output logic             A2,
  output logic             B,
  output logic             C,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
  ,
  output logic             FAIL_VLD,
  output logic [3:0]       FAIL_VEC
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  localparam logic [7:0] CNT_LD = 8'(SETTLE_CYCLES);
  localparam logic [1:0] FIRST  =
    (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fvld_q, fvld_d;
  logic [3:0]       fvec_q, fvec_d;

  logic             exp_zn;
  logic             miss;
  logic [ERR_W-1:0] err_nx;

  assign exp_zn = ~((vec_q[3] | vec_q[2]) & vec_q[1] & vec_q[0]);
  // X/Z on ZN_IN counts as a failure in simulation
  assign miss   = (ZN_IN !== exp_zn);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    err_nx  = err_q;
    if (miss && (err_q != ERR_MAX)) begin
      err_nx = err_q + 1'b1;
    end
    unique case (state_q)
      IDLE, FIN: begin
        if (START) begin
          state_d = FIRST;
          vec_d   = 4'd0;
          cnt_d   = CNT_LD;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fvld_d  = 1'b0;
          fvec_d  = 4'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        err_d = err_nx;
        if (miss && !fvld_q) begin
          fvld_d = 1'b1;
          fvec_d = vec_q;
        end
        if (vec_q == 4'd15) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_nx == '0);
        end else begin
          state_d = FIRST;
          vec_d   = vec_q + 4'd1;
          cnt_d   = CNT_LD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      cnt_q   <= 8'd0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      fvld_q <= 1'b0;
      fvec_q <= 4'd0;
    end else begin
      fvld_q <= fvld_d;
      fvec_q <= fvec_d;
    end
  end

  assign FAIL_VLD = fvld_q;
  assign FAIL_VEC = fvec_q;
`else
  assign fvld_q = 1'b0;
  assign fvec_q = 4'd0;

  logic unused_flog;
  assign unused_flog = ^{fvld_d, fvec_d};
`endif

  assign {A1, A2, B, C} = vec_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign PASS    = pass_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0_oai211_bist.sv
// Bench for the oai211 BIST: two instances (default, and SETTLE=0/ERR_W=3)
// driven by a faultable cell model; table, random and corner sequences.
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu9t5v0_oai211_bist;

  logic clk = 1'b0;
  logic rn  = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic a1_0, a2_0, b_0, c_0, busy0, done0, pass0;
  logic [4:0] err0;
  logic a1_1, a2_1, b_1, c_1, busy1, done1, pass1;
  logic [2:0] err1;
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
  logic fvld0, fvld1;
  logic [3:0] fvec0, fvec1;
`endif

  logic [15:0] mask = 16'h0;
  int xvec = -1;
  logic [3:0] v0, v1;
  logic zn0, zn1;
  assign v0 = {a1_0, a2_0, b_0, c_0};
  assign v1 = {a1_1, a2_1, b_1, c_1};
  assign zn0 = ({28'd0, v0} == xvec) ? 1'bx :
               (~((v0[3] | v0[2]) & v0[1] & v0[0]) ^ mask[v0]);
  assign zn1 = ({28'd0, v1} == xvec) ? 1'bx :
               (~((v1[3] | v1[2]) & v1[1] & v1[0]) ^ mask[v1]);

  gf180mcu_fd_sc_mcu9t5v0_oai211_bist #(
    .SETTLE_CYCLES(2), .ERR_W(5)
  ) u0 (
    .CLK(clk), .RN(rn), .START(start), .ZN_IN(zn0),
    .A1(a1_0), .A2(a2_0), .B(b_0), .C(c_0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0)
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
    , .FAIL_VLD(fvld0), .FAIL_VEC(fvec0)
`endif
  );

  gf180mcu_fd_sc_mcu9t5v0_oai211_bist #(
    .SETTLE_CYCLES(0), .ERR_W(3)
  ) u1 (
    .CLK(clk), .RN(rn), .START(start), .ZN_IN(zn1),
    .A1(a1_1), .A2(a2_1), .B(b_1), .C(c_1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1)
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
    , .FAIL_VLD(fvld1), .FAIL_VEC(fvec1)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected result of a run: every faulted or X vector is one mismatch
  function automatic void model(input logic [15:0] m, input int xv,
                                input int w, output int err,
                                output int fv);
    logic [15:0] f;
    f = m;
    if (xv >= 0) f[xv] = 1'b1;
    err = $countones(f);
    if (err > (1 << w) - 1) err = (1 << w) - 1;
    fv = 0;
    for (int i = 15; i >= 0; i--) if (f[i]) fv = i;
  endfunction

  typedef struct {
    string       nm;
    logic [15:0] mask;
    int          xv;
    int          start_at;
    int          err0;
    int          err1;
    bit          pass;
    int          fvec;
  } vec_t;

  vec_t tbl[7];

  task automatic run(input string nm, input logic [15:0] m, input int xv,
                     input int start_at, input int e0, input int e1,
                     input bit ps, input int fv);
    int d0, d1, drv_bad;
    mask = m;
    xvec = xv;
    d0 = -1;
    d1 = -1;
    drv_bad = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    if (v0 !== 4'd0 || busy0 !== 1'b1 || v1 !== 4'd0) drv_bad++;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == start_at);
      if (d0 < 0 && done0 === 1'b1) d0 = k;
      if (d1 < 0 && done1 === 1'b1) d1 = k;
      if (k < 48 && (v0 !== 4'(k / 3) || busy0 !== 1'b1)) drv_bad++;
      if (k < 16 && v1 !== 4'(k)) drv_bad++;
      if (d0 >= 0 && d1 >= 0) break;
    end
    start = 1'b0;
    chk({nm, ".done0_cyc"}, d0, 48);
    chk({nm, ".done1_cyc"}, d1, 16);
    chk({nm, ".drv_seq"}, drv_bad, 0);
    chk({nm, ".err0"}, 32'(err0), e0);
    chk({nm, ".err1"}, 32'(err1), e1);
    chk({nm, ".pass0"}, 32'(pass0), 32'(ps));
    chk({nm, ".pass1"}, 32'(pass1), 32'(ps));
`ifdef GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN
    chk({nm, ".fvld0"}, 32'(fvld0), 32'(e0 != 0));
    chk({nm, ".fvec0"}, 32'(fvec0), fv);
    chk({nm, ".fvec1"}, 32'(fvec1), fv);
`else
    if (fv < 0) $display("note: bad fvec");
`endif
    @(negedge clk);
    chk({nm, ".fin_hold"}, {v0, busy0, done0, v1, busy1, done1},
        {4'hf, 1'b0, 1'b1, 4'hf, 1'b0, 1'b1});
  endtask

  initial begin
    int e0, e1, fv;
    logic [15:0] m;

    tbl[0] = '{"good",     16'h0000, -1, -1,  0, 0, 1'b1, 0};
    tbl[1] = '{"stuck1",   16'h8880, -1, -1,  3, 3, 1'b0, 7};
    tbl[2] = '{"stuck0",   16'h777f, -1, -1, 13, 7, 1'b0, 0};
    tbl[3] = '{"rerun",    16'h0000, -1, -1,  0, 0, 1'b1, 0};
    tbl[4] = '{"x_v5",     16'h0000,  5, -1,  1, 1, 1'b0, 5};
    tbl[5] = '{"start_ig", 16'h0000, -1, 10,  0, 0, 1'b1, 0};
    tbl[6] = '{"mix",      16'h0421, -1, -1,  3, 3, 1'b0, 0};

    #2 rn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset0", {v0, busy0, done0, pass0, err0}, '0);
    chk("reset1", {v1, busy1, done1, pass1, err1}, '0);
    rn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_hold", {v0, busy0, done0, v1, busy1, done1}, '0);

    foreach (tbl[i])
      run(tbl[i].nm, tbl[i].mask, tbl[i].xv, tbl[i].start_at,
          tbl[i].err0, tbl[i].err1, tbl[i].pass, tbl[i].fvec);

    for (int r = 0; r < 6; r++) begin
      m = (r == 0) ? 16'h0 : 16'($urandom_range(0, 65535));
      if (r == 1) m = 16'h8000;
      model(m, -1, 5, e0, fv);
      model(m, -1, 3, e1, fv);
      run($sformatf("rnd%0d", r), m, -1, -1, e0, e1, m == 16'h0, fv);
    end

    // START held in FIN restarts immediately with a cleared count
    mask = 16'hffff;
    xvec = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    chk("fin_restart", {busy0, done0, pass0, err0},
        {1'b1, 1'b0, 1'b0, 5'd0});
    start = 1'b0;

    // Asynchronous reset mid-run
    repeat (19) @(negedge clk);
    #2 rn = 1'b0;
    #1;
    chk("async_rst0", {v0, busy0, done0, pass0, err0}, '0);
    chk("async_rst1", {v1, busy1, done1, pass1, err1}, '0);
    @(negedge clk) rn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {v0, busy0, done0, err0}, '0);
    run("after_rst", 16'h0, -1, -1, 0, 0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0_oai211_bist.md
Name: gf180mcu_fd_sc_mcu9t5v0_oai211_bist

Overview:
Self-checking stimulus/response engine for the oai211 cell. It drives A1/A2/B/C into a cell instance, samples the cell's ZN back, and compares it against ZN = !((A1|A2)&B&C). It sequences all 16 input vectors, counts mismatches and reports pass/fail. It sits beside a cell instance in library qualification benches and silicon test structures.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before ZN is sampled; legal range 0..255.
ERR_W, 5, width of the mismatch counter; the counter saturates at 2^ERR_W-1.

Ports:
CLK  input  1  single clock, rising-edge.
RN  input  1  asynchronous active-low reset.
START  input  1  run request, sampled on rising CLK.
ZN_IN  input  1  ZN returned from the cell under test.
A1  output  1  drive to cell A1.
A2  output  1  drive to cell A2.
B  output  1  drive to cell B.
C  output  1  drive to cell C.
BUSY  output  1  high while a run is in progress.
DONE  output  1  high once a run completes; held until the next START.
PASS  output  1  valid when DONE=1: 1 if ERR_CNT==0.
ERR_CNT  output  ERR_W  saturating mismatch count for the current or last run.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE; A1=A2=B=C=0; BUSY=DONE=PASS=0; ERR_CNT=0; vec=0; settle counter=0. Reset mid-run aborts the run with no partial result retained.
- All outputs are registered; there is no combinational path from any input to any output.
- Vector mapping: vec[3:0] = {A1,A2,B,C}. Order is 0 to 15, ascending.
- Expected value: exp = !((vec[3]|vec[2]) & vec[1] & vec[0]).
- FSM states: IDLE, SETTLE, SAMPLE, FIN.
- IDLE or FIN with START=1:
  - Clear ERR_CNT, DONE and PASS; set vec=0; BUSY=1.
  - Load settle counter with SETTLE_CYCLES.
  - Go to SETTLE, or directly to SAMPLE when SETTLE_CYCLES==0.
  - Drives show vec 0 from this edge onward.
- SETTLE: decrement the counter each cycle. When the counter reaches 1, go to SAMPLE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- SAMPLE lasts 1 cycle. At its closing edge, compare ZN_IN with exp:
  - A mismatch, including ZN_IN of X/Z in simulation (case-inequality), increments ERR_CNT.
  - ERR_CNT saturates at its maximum and never wraps.
  - If vec==15: go to FIN, BUSY=0, DONE=1, PASS=(final ERR_CNT==0). A mismatch on vec 15 is included in PASS.
  - Otherwise: vec+1, reload the counter, go to SETTLE (or SAMPLE when SETTLE_CYCLES==0).
- Latency: each vector takes SETTLE_CYCLES+1 cycles. DONE rises 16*(SETTLE_CYCLES+1) cycles after the START edge (48 with the default).
- START while BUSY=1 is ignored. START held high in FIN restarts immediately.
- In FIN the drives hold vec 15 (all ones). In IDLE they are all 0.

Optional Feature:
Macro GF180MCU_FD_SC_MCU9T5V0_OAI211_BIST_FAILLOG_EN.
- Defined:
  - Adds outputs FAIL_VLD (1 bit) and FAIL_VEC (4 bits).
  - On the first mismatch of a run, FAIL_VEC captures vec and FAIL_VLD=1. Both hold until the next START, which clears them to 0.
  - Reset value of both is 0.
- Undefined: neither port exists and there is no capture logic. All other behaviour is identical.

Test Plan:
- Correct oai211 model on ZN_IN, START pulse -> DONE=1 exactly 48 cycles after START; PASS=1; ERR_CNT=0; drives step 0..15, each held 3 cycles.
- ZN_IN stuck at 1 -> ERR_CNT=3 (vecs 7, 11, 15), PASS=0; with FAILLOG, FAIL_VEC=7.
- ZN_IN stuck at 0 with ERR_W=3 -> ERR_CNT saturates at 7 (13 mismatches), PASS=0; with FAILLOG, FAIL_VEC=0.
- SETTLE_CYCLES=0, correct model -> DONE 16 cycles after START, PASS=1; second START from FIN reruns with ERR_CNT cleared.
- START pulsed at cycle 10 of a run -> ignored; DONE still at cycle 48.
- RN low at cycle 20 -> all outputs 0 asynchronously, state IDLE; a new START gives a clean full run.
